digi_scanner: RTL and testbench
===============================

// Module: digi_scanner
// PURPOSE
//  Time-multiplexed 4-digit 7-segment driver downstream of the memory-mapped peripheral block.
//  Takes a 16-bit hex value plus per-digit decimal-point and blank masks from a CPU-written register.
//  Produces the 12-bit {anode[3:0], seg[7:0]} word that drives the board display pins.
//  Uses a shadow/active double buffer so a display update takes effect only at a frame boundary,
//  which avoids tearing.
// PARAMETERS
//  SCAN_DIV     50000  clk cycles per digit slot; legal range >= 2
//  DEAD_CYCLES  16     cycles at slot start with all anodes off (anti-ghosting); 0 <= DEAD_CYCLES < SCAN_DIV
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   synchronous, active-high
//  load        in   1   1-cycle strobe; captures value/dp/blank into shadow
//  value       in   16  hex digits; digit i = value[4i+3:4i], digit 0 rightmost
//  dp          in   4   decimal point per digit, 1 = lit
//  blank       in   4   1 = digit i segments forced off
//  digi        out  12  {anode[3:0], seg[7:0]}, all active-low; seg[7]=dp, seg[6:0]=g..a
//  frame_tick  out  1   1-cycle pulse when the digit index wraps 3->0
//  busy        out  1   1 = shadow holds data not yet applied to active
// BEHAVIOUR
//  Reset (sync, any cycle incl. mid-frame): cnt=0, idx=0, shadow=0, active=0, digi=12'hFFF,
//   frame_tick=0, busy=0.
//  cnt counts 0..SCAN_DIV-1 and then returns to 0. At cnt==SCAN_DIV-1, idx <= idx+1 (mod 4).
//  Boundary = cnt==SCAN_DIV-1 && idx==3. In the cycle after the boundary:
//   frame_tick=1; active<=shadow; busy<=0.
//  load: shadow<={value,dp,blank}, busy<=1. If load and boundary fall in the same cycle,
//   the new load data goes straight to active and busy stays 0.
//  Multiple loads within one frame: the last one wins.
//  digi is registered, 1 cycle after (cnt, idx):
//   cnt<DEAD_CYCLES -> 12'hFFF;
//   else anode = ~(4'b0001<<idx), seg = {~dp[idx], dec(nibble idx)};
//   blank[idx] -> seg=8'hFF, anode still driven.
//  dec (active-low g..a): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
//  With dp off, seg = 8'h80|dec (e.g. '4' -> 8'h99, '0' -> 8'hC0).
//  The value and mask inputs are sampled only on load. Between loads their values are don't-care.
// CONFIGURATION
//  DIGI_LZB_EN defined: leading-zero blanking on active data.
//   Digit i (i=3..1) is blanked when its nibble and all higher nibbles are 0.
//   Digit 0 is never auto-blanked. A blanked digit's dp stays visible if dp[i]=1.
//  DIGI_LZB_EN undefined: zeros display as '0'; only the blank mask blanks digits.
// TESTING (SCAN_DIV=8, DEAD_CYCLES=2)
//  1. Assert reset for 2 cycles -> digi=12'hFFF, busy=0, frame_tick=0 on the following cycle.
//  2. load value=16'h1234, dp=0, blank=0 -> busy=1 until the boundary; frame_tick pulses;
//     in slot idx0, cycles cnt=2..7 -> digi=12'hE99.
//  3. Any slot, cnt=0..1 -> digi=12'hFFF (dead time). Slot idx2 shows 12'hBA4 ('2').
//  4. load 16'hFFFF mid-frame -> display unchanged until the boundary, then idx0 shows 12'hE8E;
//     load coinciding with the boundary -> applied without a busy pulse.
//  5. blank=4'b0100, dp=4'b0001, value=16'h0000 -> idx2 digi=12'hBFF, idx0 digi=12'hE40.
//  6. DIGI_LZB_EN, value=16'h0045 -> idx3/idx2 digi=12'h7FF/12'hBFF, idx1 12'hD99, idx0 12'hE92;
//     without the macro, idx3 shows 12'h7C0.

Source files
------------

// File: rtl/digi_scanner_if.sv
// Bus between the CPU-side display register and the 4-digit 7-segment scanner.
// master drives the load strobe and register contents; slave returns the pin word and status.
interface digi_scanner_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [11:0] digi;
  logic        frame_tick;
  logic        busy;

  modport master (
    output load, value, dp, blank,
    input  digi, frame_tick, busy
  );

  modport slave (
    input  load, value, dp, blank,
    output digi, frame_tick, busy
  );
endinterface

// File: rtl/digi_scanner.sv
// Time-multiplexed 4-digit 7-segment driver with shadow/active buffering applied at frame wrap.
// Optional leading-zero blanking is enabled by defining DIGI_LZB_EN.
module digi_scanner #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  digi_scanner_if.slave bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  disp_t            shadow_reg, shadow_next;
  disp_t            active_reg, active_next;
  logic             busy_reg, busy_next;
  logic             frame_tick_reg, frame_tick_next;
  logic [11:0]      digi_reg, digi_next;

  logic             cnt_end;
  logic             boundary;
  logic             in_dead;
  disp_t            load_data;
  logic [3:0]       auto_blank;
  logic [7:0]       seg_digit [4];

  // Active-low g..a patterns for hex digits.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt_reg < DEAD_CNT);
    end
  endgenerate

  // Per-digit segment word from the active buffer; the scan mux picks one by idx.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
`ifdef DIGI_LZB_EN
      if (gi == 0) begin : g_lsd
        assign auto_blank[gi] = 1'b0;
      end else begin : g_upper
        assign auto_blank[gi] = (active_reg.value[15:4*gi] == '0);
      end
`else
      assign auto_blank[gi] = 1'b0;
`endif
      always_comb begin
        seg_digit[gi] = {~active_reg.dp[gi], seg_decode(active_reg.value[4*gi +: 4])};
        if (active_reg.blank[gi]) begin
          seg_digit[gi] = 8'hFF;
        end else if (auto_blank[gi]) begin
          seg_digit[gi] = {~active_reg.dp[gi], 7'h7F};
        end
      end
    end
  endgenerate

  always_comb begin
    cnt_end   = (cnt_reg == CNT_MAX);
    boundary  = cnt_end && (idx_reg == 2'd3);
    load_data = '{value: bus.value, dp: bus.dp, blank: bus.blank};

    cnt_next        = cnt_end ? '0 : cnt_reg + CNT_W'(1);
    idx_next        = cnt_end ? idx_reg + 2'd1 : idx_reg;
    shadow_next     = shadow_reg;
    active_next     = active_reg;
    busy_next       = busy_reg;
    frame_tick_next = boundary;

    if (bus.load) begin
      shadow_next = load_data;
      busy_next   = 1'b1;
    end
    // A load landing on the boundary bypasses the shadow so it is not held a whole frame.
    if (boundary) begin
      active_next = bus.load ? load_data : shadow_reg;
      busy_next   = 1'b0;
    end
  end

  always_comb begin
    digi_next = 12'hFFF;
    if (!in_dead) begin
      digi_next = {~(4'b0001 << idx_reg), seg_digit[idx_reg]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shadow_reg     <= '0;
      active_reg     <= '0;
      busy_reg       <= 1'b0;
      frame_tick_reg <= 1'b0;
      digi_reg       <= 12'hFFF;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shadow_reg     <= shadow_next;
      active_reg     <= active_next;
      busy_reg       <= busy_next;
      frame_tick_reg <= frame_tick_next;
      digi_reg       <= digi_next;
    end
  end

  assign bus.digi       = digi_reg;
  assign bus.frame_tick = frame_tick_reg;
  assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_digi_scanner.sv
// Directed bench for digi_scanner (SCAN_DIV=8, DEAD_CYCLES=2) with a per-frame expectation queue.
// Expected slot words are pushed when a load is driven and popped when that frame is displayed.
module tb_digi_scanner;
  localparam int SD = 8;
  localparam int DC = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [11:0] exp_q [$];

  digi_scanner_if bus ();

  digi_scanner #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    bus.load  = 1'b1;
    bus.value = v;
    bus.dp    = d;
    bus.blank = b;
    tick();
    bus.load  = 1'b0;
  endtask

  task automatic push_frame(input logic [11:0] s0, input logic [11:0] s1,
                            input logic [11:0] s2, input logic [11:0] s3);
    exp_q.push_back(s0);
    exp_q.push_back(s1);
    exp_q.push_back(s2);
    exp_q.push_back(s3);
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.frame_tick !== 1'b1 && n < 100);
    chk({tag, "_frame_tick_seen"}, {11'd0, bus.frame_tick}, 12'd1);
  endtask

  // Called in the frame_tick cycle; walks all 32 cycles of the new frame.
  task automatic check_frame(input string tag);
    logic [11:0] slot [4];
    logic [11:0] exp;
    int cyc_cnt;
    int cyc_idx;
    if (exp_q.size() < 4) begin
      chk({tag, "_queue_depth"}, 12'(exp_q.size()), 12'd4);
      return;
    end
    for (int s = 0; s < 4; s++) slot[s] = exp_q.pop_front();
    for (int n = 1; n <= 4 * SD; n++) begin
      tick();
      cyc_cnt = (n - 1) % SD;
      cyc_idx = (n - 1) / SD;
      exp = (cyc_cnt < DC) ? 12'hFFF : slot[cyc_idx];
      chk($sformatf("%s_idx%0d_cnt%0d", tag, cyc_idx, cyc_cnt), bus.digi, exp);
      if (n == 1) chk({tag, "_tick_low"}, {11'd0, bus.frame_tick}, 12'd0);
    end
    chk({tag, "_next_tick"}, {11'd0, bus.frame_tick}, 12'd1);
    $display("frame %s: slots %h %h %h %h", tag, slot[0], slot[1], slot[2], slot[3]);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.dp    = '0;
    bus.blank = '0;

    ticks(2);
    chk("reset_digi", bus.digi, 12'hFFF);
    chk("reset_busy", {11'd0, bus.busy}, 12'd0);
    chk("reset_tick", {11'd0, bus.frame_tick}, 12'd0);
    reset = 1'b0;

    // 1234: only digits, no masks
    drive_load(16'h1234, 4'b0000, 4'b0000);
    chk("load1234_busy", {11'd0, bus.busy}, 12'd1);
    push_frame(12'hE99, 12'hDB0, 12'hBA4, 12'h7F9);
    wait_frame("f1234");
    chk("f1234_busy_clear", {11'd0, bus.busy}, 12'd0);
    check_frame("f1234");

    // FFFF loaded mid-frame must not disturb the current frame
    ticks(10);
    drive_load(16'hFFFF, 4'b0000, 4'b0000);
    chk("midload_old_digit", bus.digi, 12'hDB0);
    chk("midload_busy", {11'd0, bus.busy}, 12'd1);
    push_frame(12'hE8E, 12'hD8E, 12'hB8E, 12'h78E);
    wait_frame("fFFFF");
    chk("fFFFF_busy_clear", {11'd0, bus.busy}, 12'd0);
    check_frame("fFFFF");

    // Load on the boundary cycle (cnt=7, idx=3) applies directly, no busy pulse
    ticks(4 * SD - 1);
    drive_load(16'h0000, 4'b0001, 4'b0100);
    chk("bnd_tick", {11'd0, bus.frame_tick}, 12'd1);
    chk("bnd_busy", {11'd0, bus.busy}, 12'd0);
`ifdef DIGI_LZB_EN
    push_frame(12'hE40, 12'hDFF, 12'hBFF, 12'h7FF);
`else
    push_frame(12'hE40, 12'hDC0, 12'hBFF, 12'h7C0);
`endif
    check_frame("fmask");

    // Two loads in one frame: the second wins
    ticks(3);
    drive_load(16'h9999, 4'b1111, 4'b0000);
    ticks(5);
    drive_load(16'h0045, 4'b0000, 4'b0000);
    chk("twoload_busy", {11'd0, bus.busy}, 12'd1);
`ifdef DIGI_LZB_EN
    push_frame(12'hE92, 12'hD99, 12'hBFF, 12'h7FF);
`else
    push_frame(12'hE92, 12'hD99, 12'hBC0, 12'h7C0);
`endif
    wait_frame("f0045");
    check_frame("f0045");

    // Mid-frame reset clears the pending shadow and the active buffer
    ticks(4);
    drive_load(16'h1111, 4'b0000, 4'b0000);
    chk("prereset_busy", {11'd0, bus.busy}, 12'd1);
    reset = 1'b1;
    tick();
    chk("midreset_digi", bus.digi, 12'hFFF);
    chk("midreset_busy", {11'd0, bus.busy}, 12'd0);
    chk("midreset_tick", {11'd0, bus.frame_tick}, 12'd0);
    reset = 1'b0;
`ifdef DIGI_LZB_EN
    push_frame(12'hEC0, 12'hDFF, 12'hBFF, 12'h7FF);
`else
    push_frame(12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0);
`endif
    wait_frame("fzero");
    check_frame("fzero");

    chk("queue_drained", 12'(exp_q.size()), 12'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
